// File: rtl/data_sram_resp_pkg.sv
// Shared types and helpers for the SRAM-like data-side responder.
package data_sram_resp_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_BUS_W = 32;
  localparam int STRB_W = 4;
  localparam int AGE_W = 4;

  // Transfer size encodings carried on data_sram_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } sram_size_e;

  // One queued transaction: write flag, captured read word, cycles since acceptance.
  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] rdata;
    logic [AGE_W-1:0]  age;
  } q_entry_t;

  localparam q_entry_t ENTRY_RST = '{wr: 1'b0, rdata: 32'h0000_0000, age: 4'h0};

  // Replace the byte lanes of old_word that are enabled in strb with new_word's lanes.
  function automatic logic [DATA_W-1:0] strb_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/data_sram_resp_fifo.sv
// Circular queue of outstanding transactions; each entry ages until it may complete.
module data_sram_resp_fifo
  import data_sram_resp_pkg::*;
#(
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push_i,
  input  q_entry_t push_entry_i,
  input  logic     pop_i,
  output logic     full_o,
  output logic     empty_o,
  output logic     head_ready_o,
  output q_entry_t head_o
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(LATENCY);
  // The entry becomes visible one edge after acceptance, so it is ready one
  // age step early; the registered completion then lands LATENCY edges after accept.
  localparam logic [AGE_W-1:0] AGE_RDY = AGE_W'(LATENCY - 1);

  q_entry_t          entry_q [QDEPTH];
  q_entry_t          entry_d [QDEPTH];
  logic [QDEPTH-1:0] valid_q;
  logic [QDEPTH-1:0] valid_d;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full_o       = (count_q == CNT_W'(QDEPTH));
  assign empty_o      = (count_q == {CNT_W{1'b0}});
  assign head_o       = entry_q[rd_ptr_q];
  assign head_ready_o = valid_q[rd_ptr_q] & (entry_q[rd_ptr_q].age >= AGE_RDY);
  assign push_ok_s    = push_i & ~full_o;
  assign pop_ok_s     = pop_i & valid_q[rd_ptr_q];

  // Next-state for entries, valid bits, pointers and occupancy.
  always_comb begin
    for (int i = 0; i < QDEPTH; i++) begin
      entry_d[i] = entry_q[i];
      if (push_ok_s && (wr_ptr_q == PTR_W'(i))) begin
        entry_d[i].wr    = push_entry_i.wr;
        entry_d[i].rdata = push_entry_i.rdata;
        entry_d[i].age   = {AGE_W{1'b0}};
      end else if (valid_q[i] && (entry_q[i].age < AGE_MAX)) begin
        entry_d[i].age = entry_q[i].age + AGE_W'(1);
      end else begin
        entry_d[i].age = entry_q[i].age;
      end

      if (push_ok_s && (wr_ptr_q == PTR_W'(i))) begin
        valid_d[i] = 1'b1;
      end else if (pop_ok_s && (rd_ptr_q == PTR_W'(i))) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end

    wr_ptr_d = push_ok_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_ok_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue state register; reset discards every outstanding entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        entry_q[i] <= ENTRY_RST;
      end
      valid_q  <= {QDEPTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// SRAM-like data-interface responder: word RAM, in-order completion queue, registered responses.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int QDEPTH  = 4,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  data_sram_req,
  input  logic                  data_sram_wr,
  input  logic [1:0]            data_sram_size,
  input  logic [ADDR_BUS_W-1:0] data_sram_addr,
  input  logic [STRB_W-1:0]     data_sram_wstrb,
  input  logic [DATA_W-1:0]     data_sram_wdata,
  output logic                  data_sram_addr_ok,
  output logic                  data_sram_data_ok,
  output logic [DATA_W-1:0]     data_sram_rdata,
  input  logic                  resp_stall
);

  logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0] ram_idx_s;
  logic [DATA_W-1:0] ram_rd_word_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;
  logic              addr_ok_s;
  logic              accept_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              head_ready_s;
  q_entry_t          head_s;
  q_entry_t          push_entry_s;
  logic              data_ok_q;
  logic              data_ok_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              unused_s;

  // Upper address bits alias and the byte offset never selects a word.
  assign ram_idx_s     = data_sram_addr[ADDR_W+1:2];
  assign ram_rd_word_s = mem_q[ram_idx_s];
  assign ram_wdata_s   = strb_merge(ram_rd_word_s, data_sram_wdata, data_sram_wstrb);

  // A slot freed by this cycle's pop is not offered until the next cycle.
  assign addr_ok_s = resetn & ~fifo_full_s;
  assign accept_s  = data_sram_req & addr_ok_s;
  assign ram_we_s  = accept_s & data_sram_wr;
  assign pop_s     = head_ready_s & ~resp_stall;

  assign unused_s = ^{data_sram_size, data_sram_addr[ADDR_BUS_W-1:ADDR_W+2],
                      data_sram_addr[1:0], head_s.wr, head_s.age, fifo_empty_s};

  // Build the queue entry: reads capture the RAM word now, writes complete with zero data.
  always_comb begin
    push_entry_s.wr  = data_sram_wr;
    push_entry_s.age = {AGE_W{1'b0}};
    if (data_sram_wr) begin
      push_entry_s.rdata = {DATA_W{1'b0}};
    end else begin
      push_entry_s.rdata = ram_rd_word_s;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      mem_q[ram_idx_s] <= ram_wdata_s;
    end
  end

  data_sram_resp_fifo #(
    .QDEPTH  (QDEPTH),
    .LATENCY (LATENCY)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (resetn),
    .push_i       (accept_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .full_o       (fifo_full_s),
    .empty_o      (fifo_empty_s),
    .head_ready_o (head_ready_s),
    .head_o       (head_s)
  );

  // Completion pulse follows the pop; read data holds between completions.
  always_comb begin
    data_ok_d = pop_s;
    if (pop_s) begin
      rdata_d = head_s.rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Response output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok_q <= 1'b0;
      rdata_q   <= {DATA_W{1'b0}};
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_addr_ok = addr_ok_s;
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

endmodule
